jtbubl_vtimer_gen: RTL

//  Parametrised video timing generator for the video top level: H/V counters, blanking, syncs,

---
 rtl/jtbubl_vtimer_gen_pkg.sv | 45 ++++
 rtl/jtbubl_vtimer_cnt.sv | 24 ++
 rtl/jtbubl_vtimer_gen.sv | 127 ++++++++++++
 3 files changed

// File: rtl/jtbubl_vtimer_gen_pkg.sv
// Shared timing defaults, flag bundle and the modular window helpers used by the video timer.
package jtbubl_vtimer_gen_pkg;

    localparam int DEF_W          = 9;
    localparam int DEF_HCNT_START = 0;
    localparam int DEF_HCNT_END   = 383;
    localparam int DEF_HB_START   = 256;
    localparam int DEF_HB_END     = 383;
    localparam int DEF_HS_START   = 297;
    localparam int DEF_HS_LEN     = 32;
    localparam int DEF_V_START    = 16;
    localparam int DEF_V_END      = 279;
    localparam int DEF_VB_START   = 240;
    localparam int DEF_VB_END     = 279;
    localparam int DEF_VS_START   = 254;
    localparam int DEF_VS_LEN     = 3;

    typedef struct packed {
        logic hinit;
        logic vinit;
        logic lhbl;
        logic lvbl;
        logic hs;
        logic vs;
    } vid_flags_t;

    localparam vid_flags_t FLAGS_RST = '{hinit: 1'b0, vinit: 1'b0, lhbl: 1'b1,
                                         lvbl: 1'b1, hs: 1'b0, vs: 1'b0};

    // a+d folded back into [lo,hi]; |d| never exceeds one range span
    function automatic int add_wrap(int a, int d, int lo, int hi);
        int r;
        r = a + d;
        if (r > hi)      r = r - (hi - lo + 1);
        else if (r < lo) r = r + (hi - lo + 1);
        return r;
    endfunction

    // inclusive window; s>e means the window wraps past the end of the range
    function automatic logic in_win(int v, int s, int e);
        if (s <= e) return (v >= s) && (v <= e);
        return (v >= s) || (v <= e);
    endfunction

endpackage

// File: rtl/jtbubl_vtimer_cnt.sv
// Wrap counter START..END with enable, synchronous reset and a carry on the wrapping step.
module jtbubl_vtimer_cnt #(
    parameter int W     = 9,
    parameter int START = 0,
    parameter int END   = 383
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         carry
);

    assign carry = en && (cnt == W'(END));
    // nxt is exposed so the parent can decode flags aligned with the new count
    assign nxt   = !en ? cnt : (carry ? W'(START) : cnt + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) cnt <= W'(START);
        else     cnt <= nxt;
    end

endmodule

// File: rtl/jtbubl_vtimer_gen.sv
// Parametrised video timing generator: H/V counters, blanking, syncs, init strobes, render look-ahead.
// Define JTBUBL_VTIMER_SHIFT_EN to enable frame-latched hshift/vshift sync centring.
module jtbubl_vtimer_gen
    import jtbubl_vtimer_gen_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int HCNT_START = DEF_HCNT_START,
    parameter int HCNT_END   = DEF_HCNT_END,
    parameter int HB_START   = DEF_HB_START,
    parameter int HB_END     = DEF_HB_END,
    parameter int HS_START   = DEF_HS_START,
    parameter int HS_LEN     = DEF_HS_LEN,
    parameter int V_START    = DEF_V_START,
    parameter int V_END      = DEF_V_END,
    parameter int VB_START   = DEF_VB_START,
    parameter int VB_END     = DEF_VB_END,
    parameter int VS_START   = DEF_VS_START,
    parameter int VS_LEN     = DEF_VS_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pxl_cen,
    input  logic [3:0]   hshift,
    input  logic [2:0]   vshift,
    output logic [W-1:0] H,
    output logic [W-1:0] vdump,
    output logic [W-1:0] vrender,
    output logic [W-1:0] vrender1,
    output logic         Hinit,
    output logic         Vinit,
    output logic         LHBL,
    output logic         LVBL,
    output logic         HS,
    output logic         VS
);

    localparam int HRANGE = HCNT_END - HCNT_START + 1;
    localparam int VRANGE = V_END - V_START + 1;
    localparam logic [W-1:0] VR_RST  = W'(add_wrap(V_START, 1, V_START, V_END));
    localparam logic [W-1:0] VR1_RST = W'(add_wrap(V_START, 2, V_START, V_END));

    localparam bit H_OK = HCNT_START < HCNT_END
        && HB_START >= HCNT_START && HB_START <= HCNT_END
        && HB_END   >= HCNT_START && HB_END   <= HCNT_END
        && HS_START >= HCNT_START && HS_START <= HCNT_END
        && HS_LEN >= 1 && HS_LEN <= HRANGE && HRANGE >= 8;
    localparam bit V_OK = V_START < V_END
        && VB_START >= V_START && VB_START <= V_END
        && VB_END   >= V_START && VB_END   <= V_END
        && VS_START >= V_START && VS_START <= V_END
        && VS_LEN >= 1 && VS_LEN <= VRANGE && VRANGE >= 4;

    if (!H_OK) begin : g_bad_h
        $error("jtbubl_vtimer_gen: horizontal range or window parameters are inconsistent");
    end
    if (!V_OK) begin : g_bad_v
        $error("jtbubl_vtimer_gen: vertical range or window parameters are inconsistent");
    end

    logic [W-1:0] h_nxt, v_nxt;
    logic         h_carry, v_carry_unused;
    vid_flags_t   flg;
    int           hs_lo, hs_hi, vs_lo, vs_hi;

    jtbubl_vtimer_cnt #(.W(W), .START(HCNT_START), .END(HCNT_END)) u_hcnt (
        .clk(clk), .rst(rst), .en(pxl_cen), .cnt(H), .nxt(h_nxt), .carry(h_carry)
    );

    jtbubl_vtimer_cnt #(.W(W), .START(V_START), .END(V_END)) u_vcnt (
        .clk(clk), .rst(rst), .en(h_carry), .cnt(vdump), .nxt(v_nxt), .carry(v_carry_unused)
    );

`ifdef JTBUBL_VTIMER_SHIFT_EN
    logic signed [3:0] hsh;
    logic signed [2:0] vsh;

    // latched only at frame start so a mid-frame change never tears the syncs
    always_ff @(posedge clk) begin
        if (rst) begin
            hsh <= '0;
            vsh <= '0;
        end else if (pxl_cen && flg.vinit) begin
            hsh <= hshift;
            vsh <= vshift;
        end
    end

    assign hs_lo = add_wrap(HS_START, int'(hsh), HCNT_START, HCNT_END);
    assign vs_lo = add_wrap(VS_START, int'(vsh), V_START, V_END);
`else
    logic unused_shift;
    assign unused_shift = ^{hshift, vshift};
    assign hs_lo = HS_START;
    assign vs_lo = VS_START;
`endif

    assign hs_hi = add_wrap(hs_lo, HS_LEN - 1, HCNT_START, HCNT_END);
    assign vs_hi = add_wrap(vs_lo, VS_LEN - 1, V_START, V_END);

    function automatic logic [W-1:0] v_inc(logic [W-1:0] v);
        return (v == W'(V_END)) ? W'(V_START) : v + 1'b1;
    endfunction

    // flags decode the next counts so they land in the same cycle as H/V
    always_ff @(posedge clk) begin
        if (rst) begin
            flg      <= FLAGS_RST;
            vrender  <= VR_RST;
            vrender1 <= VR1_RST;
        end else if (pxl_cen) begin
            flg.hinit <= h_nxt == W'(HCNT_START);
            flg.vinit <= (h_nxt == W'(HCNT_START)) && (v_nxt == W'(V_START));
            flg.lhbl  <= !in_win(int'(h_nxt), HB_START, HB_END);
            flg.lvbl  <= !in_win(int'(v_nxt), VB_START, VB_END);
            flg.hs    <= in_win(int'(h_nxt), hs_lo, hs_hi);
            if (int'(h_nxt) == hs_lo)
                flg.vs <= in_win(int'(v_nxt), vs_lo, vs_hi);
            if (h_carry) begin
                vrender  <= v_inc(vrender);
                vrender1 <= v_inc(vrender1);
            end
        end
    end

    assign {Hinit, Vinit, LHBL, LVBL, HS, VS} = flg;

endmodule
